pmem_arbiter: RTL and testbench

- Shares the single physical-memory port between L2 miss fills (reads) and the eviction write buffer drain (writes).
- Sits between the L2 cache, the eviction write buffer and pmem.
- Sequences one transaction at a time and gives reads priority.
- Bounds write starvation and enforces read-after-write ordering on the same line.

---
 rtl/lc3b_types.sv | 26 ++
 rtl/pmem_arb_starve_ctr.sv | 36 +++
 rtl/pmem_arbiter.sv | 131 +++++++++++++
 tb/tb_pmem_arbiter.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lc3b_types.sv
`default_nettype none
// ============================================================================
// Module      : lc3b_types (package)
// Description : Shared LC-3b memory-system types, arbiter state encoding and
//               the cache-line tag compare helper.
// Revision    : 1.0 - initial release
// ============================================================================
package lc3b_types;

    typedef logic [15:0]  lc3b_word;
    typedef logic [255:0] lc3b_pmem_data;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } pmem_arb_state_t;

    // True when both addresses fall in the same cache line.
    function automatic logic same_line(input lc3b_word a, input lc3b_word b,
                                       input int unsigned offset_bits);
        return (a >> offset_bits) == (b >> offset_bits);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pmem_arb_starve_ctr.sv
`default_nettype none
// ============================================================================
// Module      : pmem_arb_starve_ctr
// Description : Saturating count of reads granted while a write waits.
// Revision    : 1.0 - initial release
// ============================================================================
module pmem_arb_starve_ctr #(
    parameter int unsigned LIMIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    input  logic clr,
    output logic at_limit
);

    localparam int unsigned CNT_W = (LIMIT < 1) ? 1 : $clog2(LIMIT + 1);
    localparam logic [CNT_W-1:0] C_LIMIT = CNT_W'(LIMIT);
    localparam logic [CNT_W-1:0] C_ONE   = CNT_W'(1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (inc && (r_cnt != C_LIMIT)) begin
            r_cnt <= r_cnt + C_ONE;
        end
    end

    assign at_limit = (r_cnt == C_LIMIT);

endmodule
`default_nettype wire

// File: rtl/pmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : pmem_arbiter
// Description : Shares the pmem port between L2 fills and eviction drains.
//               Optional macro PMEM_ARB_FWD_EN forwards same-line hazards.
// Revision    : 1.0 - initial release
// ============================================================================
module pmem_arbiter
    import lc3b_types::*;
#(
    parameter int unsigned ADDR_W       = 16,
    parameter int unsigned LINE_W       = 256,
    parameter int unsigned OFFSET_BITS  = 5,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              l2_pmem_read,
    input  logic [ADDR_W-1:0] l2_pmem_raddress,
    output logic              l2_pmem_resp,
    output logic [LINE_W-1:0] l2_pmem_rdata,
    input  logic              ewb_valid,
    input  logic [ADDR_W-1:0] ewb_address,
    input  logic [LINE_W-1:0] ewb_wdata,
    output logic              ewb_done,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp
);

    pmem_arb_state_t   r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [LINE_W-1:0] r_wdata;
    logic              r_pmem_read;
    logic              r_pmem_write;

    logic w_idle;
    logic w_hazard;
    logic w_at_limit;
    logic w_fwd;
    logic w_grant_write;
    logic w_grant_read;
    logic w_starve_inc;
    logic w_starve_clr;

    assign w_idle   = (r_state == IDLE);
    assign w_hazard = ewb_valid && l2_pmem_read &&
                      same_line(lc3b_word'(l2_pmem_raddress),
                                lc3b_word'(ewb_address), OFFSET_BITS);

`ifdef PMEM_ARB_FWD_EN
    // A same-line read is served from the eviction buffer unless the write is overdue.
    assign w_fwd         = w_idle && w_hazard && !w_at_limit;
    assign w_grant_write = w_idle && ewb_valid && (w_at_limit || !l2_pmem_read);
`else
    assign w_fwd         = 1'b0;
    assign w_grant_write = w_idle && ewb_valid &&
                           (w_hazard || w_at_limit || !l2_pmem_read);
`endif
    assign w_grant_read  = w_idle && l2_pmem_read && !w_grant_write && !w_fwd;

    assign w_starve_inc  = w_grant_read && ewb_valid;
    assign w_starve_clr  = w_grant_write || (w_idle && !ewb_valid);

    pmem_arb_starve_ctr #(
        .LIMIT    (STARVE_LIMIT)
    ) u_starve_ctr (
        .clk      (clk),
        .rst_n    (rst_n),
        .inc      (w_starve_inc),
        .clr      (w_starve_clr),
        .at_limit (w_at_limit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_pmem_read  <= 1'b0;
            r_pmem_write <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_grant_write) begin
                        r_state      <= WRITE;
                        r_addr       <= ewb_address;
                        r_wdata      <= ewb_wdata;
                        r_pmem_write <= 1'b1;
                    end else if (w_grant_read) begin
                        r_state      <= READ;
                        r_addr       <= l2_pmem_raddress;
                        r_pmem_read  <= 1'b1;
                    end
                end
                READ: begin
                    if (pmem_resp) begin
                        r_state     <= IDLE;
                        r_pmem_read <= 1'b0;
                    end
                end
                WRITE: begin
                    if (pmem_resp) begin
                        r_state      <= IDLE;
                        r_pmem_write <= 1'b0;
                    end
                end
                default: begin
                    r_state      <= IDLE;
                    r_pmem_read  <= 1'b0;
                    r_pmem_write <= 1'b0;
                end
            endcase
        end
    end

    assign pmem_read     = r_pmem_read;
    assign pmem_write    = r_pmem_write;
    assign pmem_address  = r_addr;
    assign pmem_wdata    = r_wdata;

    assign l2_pmem_resp  = (r_pmem_read && pmem_resp) || w_fwd;
    assign l2_pmem_rdata = w_fwd                      ? ewb_wdata  :
                           (r_pmem_read && pmem_resp) ? pmem_rdata : '0;
    assign ewb_done      = r_pmem_write && pmem_resp;

endmodule
`default_nettype wire

// File: tb/tb_pmem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_pmem_arbiter
// Description : Directed bench with a transaction-level arbiter model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pmem_arbiter;

    localparam int ADDR_W       = 16;
    localparam int LINE_W       = 256;
    localparam int STARVE_LIMIT = 4;
`ifdef PMEM_ARB_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              l2_pmem_read = 1'b0;
    logic [ADDR_W-1:0] l2_pmem_raddress = '0;
    logic              l2_pmem_resp;
    logic [LINE_W-1:0] l2_pmem_rdata;
    logic              ewb_valid = 1'b0;
    logic [ADDR_W-1:0] ewb_address = '0;
    logic [LINE_W-1:0] ewb_wdata = '0;
    logic              ewb_done;
    logic              pmem_read;
    logic              pmem_write;
    logic [ADDR_W-1:0] pmem_address;
    logic [LINE_W-1:0] pmem_wdata;
    logic [LINE_W-1:0] pmem_rdata;
    logic              pmem_resp;
    logic              resp_r = 1'b0;
    logic              stray = 1'b0;

    always #5 clk = ~clk;

    pmem_arbiter #(
        .ADDR_W       (ADDR_W),
        .LINE_W       (LINE_W),
        .OFFSET_BITS  (5),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .l2_pmem_read     (l2_pmem_read),
        .l2_pmem_raddress (l2_pmem_raddress),
        .l2_pmem_resp     (l2_pmem_resp),
        .l2_pmem_rdata    (l2_pmem_rdata),
        .ewb_valid        (ewb_valid),
        .ewb_address      (ewb_address),
        .ewb_wdata        (ewb_wdata),
        .ewb_done         (ewb_done),
        .pmem_read        (pmem_read),
        .pmem_write       (pmem_write),
        .pmem_address     (pmem_address),
        .pmem_wdata       (pmem_wdata),
        .pmem_rdata       (pmem_rdata),
        .pmem_resp        (pmem_resp)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [LINE_W-1:0] act,
                         input logic [LINE_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s actual=timeout required=response", name);
    endtask

    // Memory returns a line derived from its address.
    assign pmem_rdata = {16{pmem_address ^ 16'h5A5A}};
    assign pmem_resp  = resp_r | stray;

    int resp_delay = 2;
    int resp_cnt   = 0;
    initial begin
        forever begin
            @(posedge clk); #1;
            if (!rst_n || !(pmem_read || pmem_write)) begin
                resp_cnt = 0;
                resp_r   = 1'b0;
            end else begin
                resp_cnt++;
                resp_r = (resp_cnt == resp_delay);
            end
        end
    end

    // Transaction-level model: one outstanding job, starvation count, grant log.
    int               m_busy = 0;   // 0 none, 1 read, 2 write
    logic [15:0]      m_addr = '0;
    logic [255:0]     m_data = '0;
    int               m_starve = 0;
    logic             prev_rd = 1'b0;
    logic             prev_wr = 1'b0;
    logic [16:0]      log_q[$];
    int               rd_cycles = 0;
    int               done_cnt = 0;

    always @(negedge clk) begin : b_model
        logic hz;
        logic forced;
        logic fwd_now;
        logic wwin;
        if (!rst_n) begin
            m_busy   = 0;
            m_starve = 0;
            prev_rd  = 1'b0;
            prev_wr  = 1'b0;
        end else begin
            hz      = ewb_valid && l2_pmem_read &&
                      (l2_pmem_raddress[15:5] == ewb_address[15:5]);
            forced  = (m_starve >= STARVE_LIMIT);
            fwd_now = FWD && (m_busy == 0) && hz && !forced;

            check("pmem_read", pmem_read, m_busy == 1);
            check("pmem_write", pmem_write, m_busy == 2);
            if (m_busy != 0) check("pmem_address", pmem_address, m_addr);
            if (m_busy == 2) check("pmem_wdata", pmem_wdata, m_data);
            check("l2_pmem_resp", l2_pmem_resp, ((m_busy == 1) && pmem_resp) || fwd_now);
            if (m_busy == 1 && pmem_resp)
                check("l2_pmem_rdata", l2_pmem_rdata, {16{m_addr ^ 16'h5A5A}});
            if (fwd_now) check("l2_pmem_rdata_fwd", l2_pmem_rdata, ewb_wdata);
            check("ewb_done", ewb_done, (m_busy == 2) && pmem_resp);

            if (pmem_read && !prev_rd)  log_q.push_back({1'b0, pmem_address});
            if (pmem_write && !prev_wr) log_q.push_back({1'b1, pmem_address});
            prev_rd = pmem_read;
            prev_wr = pmem_write;
            if (pmem_read) rd_cycles++;
            if (ewb_done)  done_cnt++;

            if (m_busy != 0) begin
                if (pmem_resp) m_busy = 0;
            end else if (!fwd_now) begin
                wwin = ewb_valid && ((hz && !FWD) || forced || !l2_pmem_read);
                if (wwin) begin
                    m_busy   = 2;
                    m_addr   = ewb_address;
                    m_data   = ewb_wdata;
                    m_starve = 0;
                end else if (l2_pmem_read) begin
                    m_busy = 1;
                    m_addr = l2_pmem_raddress;
                    if (ewb_valid && m_starve < STARVE_LIMIT) m_starve++;
                end
                if (!ewb_valid) m_starve = 0;
            end
        end
    end

    // Agents are entered just after a rising edge and return just after one.
    logic [255:0] l2_got;
    logic [15:0]  ewb_addr_at_done;
    logic [255:0] ewb_wdata_at_done;

    task automatic l2_req(input logic [15:0] a);
        int n;
        l2_pmem_read     = 1'b1;
        l2_pmem_raddress = a;
        n = 0;
        do begin @(negedge clk); n++; end while (!l2_pmem_resp && n < 300);
        if (!l2_pmem_resp) timeout_fail("l2_wait");
        l2_got = l2_pmem_rdata;
        @(posedge clk); #1;
        l2_pmem_read = 1'b0;
    endtask

    task automatic ewb_req(input logic [15:0] a, input logic [255:0] d);
        int n;
        ewb_valid   = 1'b1;
        ewb_address = a;
        ewb_wdata   = d;
        n = 0;
        do begin @(negedge clk); n++; end while (!ewb_done && n < 300);
        if (!ewb_done) timeout_fail("ewb_wait");
        ewb_addr_at_done  = pmem_address;
        ewb_wdata_at_done = pmem_wdata;
        @(posedge clk); #1;
        ewb_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic start_test();
        log_q.delete();
        rd_cycles = 0;
        done_cnt  = 0;
    endtask

    initial begin : b_main
        int n;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_pmem_read", pmem_read, 1'b0);
        check("rst_pmem_write", pmem_write, 1'b0);
        check("rst_pmem_address", pmem_address, 16'h0);
        check("rst_pmem_wdata", pmem_wdata, '0);
        check("rst_l2_rdata", l2_pmem_rdata, '0);

        // Asynchronous reset in the middle of a read
        @(posedge clk); #1;
        resp_delay       = 10;
        l2_pmem_read     = 1'b1;
        l2_pmem_raddress = 16'h1100;
        n = 0;
        do begin @(negedge clk); n++; end while (!pmem_read && n < 20);
        if (!pmem_read) timeout_fail("t1_strobe");
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check("t1_async_pmem_read", pmem_read, 1'b0);
        check("t1_async_pmem_write", pmem_write, 1'b0);
        check("t1_async_address", pmem_address, 16'h0);
        check("t1_async_l2_resp", l2_pmem_resp, 1'b0);
        l2_pmem_read = 1'b0;
        idle(2);
        rst_n = 1'b1;
        idle(2);

        // Lone read
        start_test();
        resp_delay = 3;
        l2_req(16'h1240);
        idle(2);
        check("t2_read_cycles", rd_cycles, 3);
        check("t2_rdata", l2_got, {16{16'h481A}});
        check("t2_log_n", log_q.size(), 1);
        if (log_q.size() >= 1) check("t2_log0", log_q[0], 17'h01240);

        // Simultaneous read and write: read first
        start_test();
        resp_delay = 2;
        fork
            l2_req(16'h2000);
            ewb_req(16'h3000, {8{32'hDEAD_BEEF}});
        join
        idle(2);
        check("t3_log_n", log_q.size(), 2);
        if (log_q.size() >= 2) begin
            check("t3_log0", log_q[0], 17'h02000);
            check("t3_log1", log_q[1], 17'h13000);
        end
        check("t3_wdata", ewb_wdata_at_done, {8{32'hDEAD_BEEF}});
        check("t3_done_cnt", done_cnt, 1);

        // Starvation bound
        start_test();
        resp_delay = 1;
        fork
            ewb_req(16'h6000, {4{64'h0123_4567_89AB_CDEF}});
            for (int i = 1; i <= 5; i++) l2_req(16'(i * 16'h0100));
        join
        idle(2);
        check("t4_log_n", log_q.size(), 6);
        if (log_q.size() >= 6) begin
            check("t4_log0", log_q[0], 17'h00100);
            check("t4_log3", log_q[3], 17'h00400);
            check("t4_log4", log_q[4], 17'h16000);
            check("t4_log5", log_q[5], 17'h00500);
        end

        // Same-line hazard
        start_test();
        resp_delay = 2;
        fork
            ewb_req(16'h4A00, {8{32'hCAFE_F00D}});
            l2_req(16'h4A1E);
        join
        idle(2);
        if (FWD) begin
            check("t5_fwd_rdata", l2_got, {8{32'hCAFE_F00D}});
            check("t5_log_n", log_q.size(), 1);
            if (log_q.size() >= 1) check("t5_log0", log_q[0], 17'h14A00);
        end else begin
            check("t5_rdata", l2_got, {16{16'h1044}});
            check("t5_log_n", log_q.size(), 2);
            if (log_q.size() >= 2) begin
                check("t5_log0", log_q[0], 17'h14A00);
                check("t5_log1", log_q[1], 17'h04A1E);
            end
        end

        // Input churn during a write
        start_test();
        resp_delay = 4;
        fork
            ewb_req(16'h5000, {8{32'h1357_9BDF}});
            begin
                n = 0;
                do begin @(negedge clk); n++; end while (!pmem_write && n < 20);
                @(posedge clk); #1;
                ewb_address = 16'h7FE0;
                ewb_wdata   = {8{32'hFFFF_0000}};
            end
        join
        idle(2);
        check("t6_addr_at_done", ewb_addr_at_done, 16'h5000);
        check("t6_wdata_at_done", ewb_wdata_at_done, {8{32'h1357_9BDF}});

        // Stray pmem_resp while idle
        stray = 1'b1;
        @(negedge clk);
        check("t7_stray_l2_resp", l2_pmem_resp, 1'b0);
        check("t7_stray_done", ewb_done, 1'b0);
        @(posedge clk); #1;
        stray = 1'b0;
        idle(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
